// File: rtl/move_queue.sv
// move_queue: unpacks packed move bursts into a circular buffer and dispenses them one at a time to move_to_step.
// Optional feature MOVE_MERGE_EN: an incoming move that is the inverse of the unpopped tail entry cancels it.
module move_queue #(
   parameter int DEPTH  = 256,
   parameter int BURST  = 50,
   parameter int MOVE_W = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    new_moves,
   input  logic [BURST*MOVE_W-1:0] seq,
   input  logic                    seq_complete,
   input  logic                    move_done,
   output logic [MOVE_W-1:0]       next_move,
   output logic                    start_move,
   output logic                    finished_queue,
   output logic                    seq_done,
   output logic [7:0]              num_moves,
   output logic [7:0]              curr_step,
   output logic                    overflow
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int IDX_W = $clog2(BURST);

   typedef enum logic {L_IDLE, L_UNPACK} loadState_t;
   typedef enum logic [1:0] {D_IDLE, D_ISSUE, D_BUSY} dispState_t;

   loadState_t r_loadState;
   loadState_t w_loadNext;
   dispState_t r_dispState;
   dispState_t w_dispNext;

   logic [BURST*MOVE_W-1:0] r_shadow;
   logic [IDX_W-1:0]        r_idx;
   logic [MOVE_W-1:0]       r_buf [DEPTH];
   logic [PTR_W-1:0]        r_wrPtr;
   logic [PTR_W-1:0]        r_rdPtr;
   logic [CNT_W-1:0]        r_count;
   logic [CNT_W-1:0]        w_countNext;
   logic                    r_armed;
   logic                    r_finished;
   logic [MOVE_W-1:0]       r_nextMove;
   logic [7:0]              r_numMoves;
   logic [7:0]              r_currStep;
   logic                    r_overflow;

   logic [MOVE_W-1:0] w_curMove;
   logic [MOVE_W-1:0] w_aheadMove;
   logic              w_unpacking;
   logic              w_curValid;
   logic              w_lastMove;
   logic              w_full;
   logic              w_write;
   logic              w_drop;
   logic              w_cancel;
   logic              w_pop;
   logic              w_seqDone;
   logic              w_startMove;
   logic              w_stepDone;

   function automatic logic isValid(input logic [MOVE_W-1:0] code);
      return (code >= MOVE_W'(2)) && (code <= MOVE_W'(13));
   endfunction

   // The shadow shifts down each cycle, so the move being examined is always in the low slot.
   assign w_curMove   = r_shadow[MOVE_W-1:0];
   assign w_aheadMove = r_shadow[2*MOVE_W-1:MOVE_W];
   assign w_unpacking = (r_loadState == L_UNPACK);
   assign w_curValid  = w_unpacking && isValid(w_curMove);
   assign w_lastMove  = (r_idx == IDX_W'(BURST - 1)) || !isValid(w_curMove) || !isValid(w_aheadMove);
   assign w_full      = (r_count == CNT_W'(DEPTH));

`ifdef MOVE_MERGE_EN
   logic [MOVE_W-1:0] w_tailMove;
   assign w_tailMove = r_buf[r_wrPtr - PTR_W'(1)];
   // A same-cycle pop of the only entry means the tail is already gone to the stepper.
   assign w_cancel   = w_curValid
                       && (r_count > (w_pop ? CNT_W'(1) : CNT_W'(0)))
                       && ((w_tailMove ^ w_curMove) == MOVE_W'(1));
`else
   assign w_cancel   = 1'b0;
`endif

   assign w_write = w_curValid && !w_cancel && !w_full;
   assign w_drop  = w_curValid && !w_cancel && w_full;

   always_comb begin
      w_loadNext = r_loadState;
      case (r_loadState)
         L_IDLE:   if (new_moves) w_loadNext = L_UNPACK;
         L_UNPACK: if (w_lastMove) w_loadNext = L_IDLE;
         default:  w_loadNext = L_IDLE;
      endcase
   end

   always_comb begin
      w_dispNext  = r_dispState;
      w_pop       = 1'b0;
      w_seqDone   = 1'b0;
      w_startMove = 1'b0;
      w_stepDone  = 1'b0;
      case (r_dispState)
         D_IDLE: begin
            if (r_armed && (r_count != '0)) begin
               w_pop      = 1'b1;
               w_dispNext = D_ISSUE;
            end else if (r_armed && (r_loadState == L_IDLE)) begin
               w_seqDone = 1'b1;
            end
         end
         D_ISSUE: begin
            w_startMove = 1'b1;
            w_dispNext  = D_BUSY;
         end
         D_BUSY: begin
            if (move_done) begin
               w_stepDone = 1'b1;
               w_dispNext = D_IDLE;
            end
         end
         default: w_dispNext = D_IDLE;
      endcase
   end

   always_comb begin
      w_countNext = r_count;
      if (w_write)  w_countNext = w_countNext + CNT_W'(1);
      if (w_cancel) w_countNext = w_countNext - CNT_W'(1);
      if (w_pop)    w_countNext = w_countNext - CNT_W'(1);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_loadState <= L_IDLE;
         r_dispState <= D_IDLE;
         r_shadow    <= '0;
         r_idx       <= '0;
         r_wrPtr     <= '0;
         r_rdPtr     <= '0;
         r_count     <= '0;
         r_armed     <= 1'b0;
         r_finished  <= 1'b0;
         r_nextMove  <= '0;
         r_numMoves  <= '0;
         r_currStep  <= '0;
         r_overflow  <= 1'b0;
      end else begin
         r_loadState <= w_loadNext;
         r_dispState <= w_dispNext;
         r_count     <= w_countNext;
         r_finished  <= w_unpacking && w_lastMove;

         if ((r_loadState == L_IDLE) && new_moves) begin
            r_shadow <= seq;
            r_idx    <= '0;
         end else if (w_unpacking) begin
            r_shadow <= {{MOVE_W{1'b0}}, r_shadow[BURST*MOVE_W-1:MOVE_W]};
            r_idx    <= r_idx + IDX_W'(1);
         end

         if (w_write) begin
            r_wrPtr <= r_wrPtr + PTR_W'(1);
         end else if (w_cancel) begin
            r_wrPtr <= r_wrPtr - PTR_W'(1);
         end

         if (w_write && (r_numMoves != 8'hFF)) begin
            r_numMoves <= r_numMoves + 8'd1;
         end else if (w_cancel && (r_numMoves != 8'h00)) begin
            r_numMoves <= r_numMoves - 8'd1;
         end

         if (w_drop) r_overflow <= 1'b1;

         if (w_pop) begin
            r_nextMove <= r_buf[r_rdPtr];
            r_rdPtr    <= r_rdPtr + PTR_W'(1);
         end

         if (w_stepDone && (r_currStep != 8'hFF)) r_currStep <= r_currStep + 8'd1;

         // A repeated seq_complete while armed must not extend the drain past its seq_done.
         if (w_seqDone) begin
            r_armed <= 1'b0;
         end else if (seq_complete) begin
            r_armed <= 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (w_write) r_buf[r_wrPtr] <= w_curMove;
   end

   assign next_move      = r_nextMove;
   assign start_move     = w_startMove;
   assign finished_queue = r_finished;
   assign seq_done       = w_seqDone;
   assign num_moves      = r_numMoves;
   assign curr_step      = r_currStep;
   assign overflow       = r_overflow;

endmodule

// File: tb/tb_move_queue.sv
// tb_move_queue: directed bench for move_queue; expected move codes go into a scoreboard
// queue as bursts are driven and are popped as the DUT issues start_move.
module tb_move_queue;
   localparam int DEPTH  = 256;
   localparam int BURST  = 50;
   localparam int MOVE_W = 4;
   localparam int SEQ_W  = BURST * MOVE_W;

   logic               clock = 1'b0;
   logic               reset;
   logic               new_moves;
   logic [SEQ_W-1:0]   seq;
   logic               seq_complete;
   logic               move_done;
   logic [MOVE_W-1:0]  next_move;
   logic               start_move;
   logic               finished_queue;
   logic               seq_done;
   logic [7:0]         num_moves;
   logic [7:0]         curr_step;
   logic               overflow;

   int checks = 0;
   int errors = 0;
   logic [MOVE_W-1:0] sb[$];
   int   expNum      = 0;
   int   expStep     = 0;
   logic expOverflow = 1'b0;

   move_queue #(.DEPTH(DEPTH), .BURST(BURST), .MOVE_W(MOVE_W)) dut (
      .clock          (clock),
      .reset          (reset),
      .new_moves      (new_moves),
      .seq            (seq),
      .seq_complete   (seq_complete),
      .move_done      (move_done),
      .next_move      (next_move),
      .start_move     (start_move),
      .finished_queue (finished_queue),
      .seq_done       (seq_done),
      .num_moves      (num_moves),
      .curr_step      (curr_step),
      .overflow       (overflow)
   );

   // 25 MHz clock; all driving and sampling happens on the falling edge.
   always #20 clock = ~clock;

   initial begin
      #4000000;
      $display("[TB] FAIL watchdog: run did not complete, observed %0d checks, required completion", checks);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   function automatic logic moveValid(input logic [MOVE_W-1:0] code);
      return (code >= 4'd2) && (code <= 4'd13);
   endfunction

   // Reference model of one stored move: merge, overflow drop and saturating num_moves.
   function automatic void sbPush(input logic [MOVE_W-1:0] code);
`ifdef MOVE_MERGE_EN
      if ((sb.size() > 0) && ((sb[$] ^ code) == 4'd1)) begin
         void'(sb.pop_back());
         if (expNum != 0) expNum--;
         return;
      end
`endif
      if (sb.size() < DEPTH) begin
         sb.push_back(code);
         if (expNum != 255) expNum++;
      end else begin
         expOverflow = 1'b1;
      end
   endfunction

   function automatic int pushBurst(input logic [SEQ_W-1:0] burst);
      int n = 0;
      logic [MOVE_W-1:0] code;
      for (int k = 0; k < BURST; k++) begin
         code = burst[k*MOVE_W +: MOVE_W];
         if (!moveValid(code)) break;
         sbPush(code);
         n++;
      end
      return n;
   endfunction

   function automatic int expLatency(input int nValid);
      return (nValid == 0) ? 2 : nValid + 1;
   endfunction

   task automatic applyStimulus(input logic [SEQ_W-1:0] burst, output int nValid);
      new_moves = 1'b1;
      seq       = burst;
      tick();
      new_moves = 1'b0;
      seq       = '0;
      nValid    = pushBurst(burst);
   endtask

   task automatic waitFinished(input int startLat, input int expLat, input string tag);
      int   lat      = startLat;
      logic sawStart = start_move;
      while (!finished_queue && (lat < 80)) begin
         tick();
         lat++;
         sawStart = sawStart | start_move;
      end
      checkOutput({tag, " finished latency"}, 32'(lat), 32'(expLat));
      checkOutput({tag, " no start while unarmed"}, 32'(sawStart), 32'd0);
      tick();
      checkOutput({tag, " finished one cycle"}, 32'(finished_queue), 32'd0);
   endtask

   task automatic drainQueue(input int nMoves, input string tag);
      int waitCyc;
      logic [MOVE_W-1:0] expCode;
      seq_complete = 1'b1;
      tick();
      seq_complete = 1'b0;
      for (int k = 0; k < nMoves; k++) begin
         waitCyc = 1;
         while (!start_move && (waitCyc < 40)) begin
            tick();
            waitCyc++;
         end
         checkOutput({tag, " start_move latency"}, 32'(waitCyc), 32'd2);
         expCode = 4'hF;
         if (sb.size() > 0) expCode = sb.pop_front();
         checkOutput({tag, " next_move order"}, 32'(next_move), 32'(expCode));
         tick();
         checkOutput({tag, " start_move one cycle"}, 32'(start_move), 32'd0);
         repeat (4) tick();
         move_done = 1'b1;
         tick();
         move_done = 1'b0;
         if (expStep != 255) expStep++;
         checkOutput({tag, " next_move held"}, 32'(next_move), 32'(expCode));
      end
      checkOutput({tag, " seq_done after drain"}, 32'(seq_done), 32'd1);
      checkOutput({tag, " curr_step"}, 32'(curr_step), 32'(expStep));
      tick();
      checkOutput({tag, " seq_done one cycle"}, 32'(seq_done), 32'd0);
      checkOutput({tag, " no start after drain"}, 32'(start_move), 32'd0);
   endtask

   initial begin
      int n;
      int cnt;
      logic [SEQ_W-1:0] burst;

      reset        = 1'b0;
      new_moves    = 1'b0;
      seq          = '0;
      seq_complete = 1'b0;
      move_done    = 1'b0;
      tick();
      tick();
      $display("[TB] reset state");
      checkOutput("reset next_move", 32'(next_move), 32'd0);
      checkOutput("reset start_move", 32'(start_move), 32'd0);
      checkOutput("reset finished_queue", 32'(finished_queue), 32'd0);
      checkOutput("reset seq_done", 32'(seq_done), 32'd0);
      checkOutput("reset num_moves", 32'(num_moves), 32'd0);
      checkOutput("reset curr_step", 32'(curr_step), 32'd0);
      checkOutput("reset overflow", 32'(overflow), 32'd0);
      reset = 1'b1;
      tick();

      $display("[TB] seq_complete on empty queue");
      seq_complete = 1'b1;
      tick();
      seq_complete = 1'b0;
      checkOutput("empty seq_done", 32'(seq_done), 32'd1);
      checkOutput("empty no start", 32'(start_move), 32'd0);
      tick();
      checkOutput("empty seq_done one cycle", 32'(seq_done), 32'd0);
      checkOutput("empty still no start", 32'(start_move), 32'd0);

      $display("[TB] burst 2,4,6");
      burst        = '0;
      burst[3:0]   = 4'd2;
      burst[7:4]   = 4'd4;
      burst[11:8]  = 4'd6;
      applyStimulus(burst, n);
      waitFinished(1, expLatency(n), "b246");
      checkOutput("b246 num_moves", 32'(num_moves), 32'(expNum));
      drainQueue(sb.size(), "b246");

      $display("[TB] burst with leading terminator");
      burst      = '0;
      burst[7:4] = 4'd5;
      applyStimulus(burst, n);
      waitFinished(1, expLatency(n), "term0");
      checkOutput("term0 num_moves", 32'(num_moves), 32'(expNum));
      drainQueue(sb.size(), "term0");

      $display("[TB] new_moves during unpack");
      burst         = '0;
      burst[3:0]    = 4'd3;
      burst[7:4]    = 4'd5;
      burst[11:8]   = 4'd7;
      burst[15:12]  = 4'd9;
      burst[19:16]  = 4'd11;
      new_moves = 1'b1;
      seq       = burst;
      tick();
      new_moves = 1'b0;
      seq       = '0;
      n = pushBurst(burst);
      tick();
      new_moves = 1'b1;
      seq       = {BURST{4'hD}};
      tick();
      new_moves = 1'b0;
      seq       = '0;
      waitFinished(3, expLatency(n), "midburst");
      cnt = 0;
      repeat (60) begin
         tick();
         cnt += 32'(finished_queue);
      end
      checkOutput("midburst no second burst", 32'(cnt), 32'd0);
      checkOutput("midburst num_moves", 32'(num_moves), 32'(expNum));
      drainQueue(sb.size(), "midburst");

      $display("[TB] burst 2,3,4");
      burst       = '0;
      burst[3:0]  = 4'd2;
      burst[7:4]  = 4'd3;
      burst[11:8] = 4'd4;
      applyStimulus(burst, n);
      waitFinished(1, expLatency(n), "b234");
      checkOutput("b234 num_moves", 32'(num_moves), 32'(expNum));
      drainQueue(sb.size(), "b234");

      $display("[TB] six full bursts");
      checkOutput("overflow clear before fill", 32'(overflow), 32'd0);
      for (int b = 0; b < 6; b++) begin
         burst = '0;
         for (int m = 0; m < BURST; m++) begin
            burst[m*MOVE_W +: MOVE_W] = MOVE_W'(2 + (((b * BURST) + m) * 5) % 12);
         end
         applyStimulus(burst, n);
         waitFinished(1, expLatency(n), "full");
      end
      checkOutput("full num_moves", 32'(num_moves), 32'(expNum));
      checkOutput("full overflow", 32'(overflow), 32'(expOverflow));
      drainQueue(sb.size(), "full");
      checkOutput("overflow sticky", 32'(overflow), 32'(expOverflow));

      $display("[TB] reset while busy");
      burst      = '0;
      burst[3:0] = 4'd8;
      burst[7:4] = 4'd10;
      applyStimulus(burst, n);
      waitFinished(1, expLatency(n), "busy");
      seq_complete = 1'b1;
      tick();
      seq_complete = 1'b0;
      cnt = 0;
      while (!start_move && (cnt < 20)) begin
         tick();
         cnt++;
      end
      checkOutput("busy start seen", 32'(start_move), 32'd1);
      checkOutput("busy next_move", 32'(next_move), 32'(sb[0]));
      tick();
      tick();
      #5 reset = 1'b0;
      #1;
      checkOutput("async reset next_move", 32'(next_move), 32'd0);
      checkOutput("async reset start_move", 32'(start_move), 32'd0);
      checkOutput("async reset num_moves", 32'(num_moves), 32'd0);
      checkOutput("async reset curr_step", 32'(curr_step), 32'd0);
      checkOutput("async reset overflow", 32'(overflow), 32'd0);
      checkOutput("async reset seq_done", 32'(seq_done), 32'd0);
      sb.delete();
      expNum      = 0;
      expStep     = 0;
      expOverflow = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      move_done = 1'b1;
      tick();
      move_done = 1'b0;
      checkOutput("post reset move_done ignored", 32'(curr_step), 32'(expStep));
      cnt = 0;
      repeat (10) begin
         tick();
         cnt += 32'(start_move) + 32'(seq_done);
      end
      checkOutput("post reset idle", 32'(cnt), 32'd0);
      checkOutput("post reset num_moves", 32'(num_moves), 32'(expNum));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
